// File: rtl/resistive_mixer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | resistive_mixer_sequencer                                                  |
// | Time-multiplexed N-channel resistive mixer built on one shared 16x17 MAC.  |
// | Optional feature macro: MIXER_SEQ_OVERRUN_CNT_EN (adds overrun_cnt).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module resistive_mixer_sequencer #(
  parameter int     N  = 4,
  parameter longint R0 = 10000,
  parameter longint R1 = 10000,
  parameter longint R2 = 10000,
  parameter longint R3 = 10000,
  parameter longint R4 = 10000,
  parameter longint R5 = 10000,
  parameter longint R6 = 10000,
  parameter longint R7 = 10000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_en,
  input  logic [15:0] inputs [N-1:0],
  input  logic [N-1:0] mute,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
`ifdef MIXER_SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]  overrun_cnt
`endif
);

  localparam longint     c_r [8] = '{R0, R1, R2, R3, R4, R5, R6, R7};
  localparam logic [2:0] c_last  = 3'(N - 1);

  function automatic longint f_cond(input int i);
    return (longint'(1) <<< 32) / c_r[i];
  endfunction

  // Normalised conductance; weights of unused channel slots are zero.
  function automatic logic [16:0] f_weight(input int i);
    longint sum;
    sum = 0;
    for (int j = 0; j < N; j++) sum += f_cond(j);
    if (i >= N) return 17'd0;
    return 17'((f_cond(i) <<< 16) / sum);
  endfunction

  localparam logic [16:0] c_w [8] = '{f_weight(0), f_weight(1), f_weight(2), f_weight(3),
                                      f_weight(4), f_weight(5), f_weight(6), f_weight(7)};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [35:0] r_acc;
  logic [15:0] r_in_s [8];
  logic [7:0]  r_mute_s;

  logic [15:0] w_in_pad [8];
  logic [7:0]  w_mute_pad;
  logic [15:0] w_data;
  logic [16:0] w_weight;
  logic [32:0] w_prod;

  // Pad the channel vector to 8 so the 3-bit index never leaves the array.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < N) begin : g_used
        assign w_in_pad[gi] = inputs[gi];
      end else begin : g_unused
        assign w_in_pad[gi] = 16'd0;
      end
    end
  endgenerate

  assign w_mute_pad = 8'(mute);
  assign w_data     = r_mute_s[r_idx] ? 16'd0 : r_in_s[r_idx];
  assign w_weight   = c_w[r_idx];
  assign w_prod     = 33'(w_data) * 33'(w_weight);
  assign busy       = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= 3'd0;
      r_acc     <= 36'd0;
      r_mute_s  <= 8'd0;
      for (int i = 0; i < 8; i++) r_in_s[i] <= 16'd0;
      out       <= 16'd0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sample_en) begin
            r_in_s   <= w_in_pad;
            r_mute_s <= w_mute_pad;
            r_acc    <= 36'd0;
            r_idx    <= 3'd0;
            r_state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          overrun <= sample_en;
          r_acc   <= r_acc + 36'(w_prod);
          r_idx   <= r_idx + 3'd1;
          if (r_idx == c_last) r_state <= ST_DONE;
        end
        ST_DONE: begin
          overrun   <= sample_en;
          out       <= r_acc[31:16];
          out_valid <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MIXER_SEQ_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_cnt <= 8'd0;
    end else if (sample_en && (r_state != ST_IDLE) && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_resistive_mixer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_resistive_mixer_sequencer                                               |
// | Directed bench: a 2-channel unequal-R mixer and a 4-channel equal-R mixer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_resistive_mixer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        se2, se4;
  logic [15:0] in2 [1:0];
  logic [15:0] in4 [3:0];
  logic [1:0]  mute2;
  logic [3:0]  mute4;
  logic [15:0] out2, out4;
  logic        val2, val4, busy2, busy4, ovr2, ovr4;
`ifdef MIXER_SEQ_OVERRUN_CNT_EN
  logic [7:0]  cnt2, cnt4;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // dut2: G0=429496, G1=143165, sum=572661 -> W0=49152, W1=16383
  resistive_mixer_sequencer #(.N(2), .R0(10000), .R1(30000)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .sample_en(se2), .inputs(in2), .mute(mute2),
    .out(out2), .out_valid(val2), .busy(busy2), .overrun(ovr2)
`ifdef MIXER_SEQ_OVERRUN_CNT_EN
    , .overrun_cnt(cnt2)
`endif
  );

  // dut4: four equal R -> W=16384 each, result = floor(sum/4)
  resistive_mixer_sequencer #(.N(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .sample_en(se4), .inputs(in4), .mute(mute4),
    .out(out4), .out_valid(val4), .busy(busy4), .overrun(ovr4)
`ifdef MIXER_SEQ_OVERRUN_CNT_EN
    , .overrun_cnt(cnt4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Called at a negedge; the strobe is sampled at the next posedge (E0).
  task automatic mix2(input logic [15:0] a0, input logic [15:0] a1, input logic [1:0] m,
                      input logic [15:0] exp, input string tag);
    in2[0] = a0; in2[1] = a1; mute2 = m; se2 = 1'b1;
    @(negedge clk);
    se2 = 1'b0;
    check({tag, ".busy0"}, 32'(busy2), 32'd1);
    in2[0] = 16'hFFFF; in2[1] = 16'h1234; mute2 = ~m;
    @(negedge clk);
    check({tag, ".val1"}, 32'(val2), 32'd0);
    @(negedge clk);
    check({tag, ".val2"}, 32'(val2), 32'd0);
    check({tag, ".busy2"}, 32'(busy2), 32'd1);
    @(negedge clk);
    check({tag, ".val3"}, 32'(val2), 32'd1);
    check({tag, ".out"}, 32'(out2), 32'(exp));
    check({tag, ".busy3"}, 32'(busy2), 32'd0);
  endtask

  task automatic mix4(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                      input logic [15:0] a3, input logic [3:0] m, input logic [15:0] exp,
                      input logic chg, input logic dbl, input string tag);
    in4[0] = a0; in4[1] = a1; in4[2] = a2; in4[3] = a3; mute4 = m; se4 = 1'b1;
    @(negedge clk);
    se4 = 1'b0;
    check({tag, ".busy0"}, 32'(busy4), 32'd1);
    check({tag, ".val0"}, 32'(val4), 32'd0);
    check({tag, ".ovr0"}, 32'(ovr4), 32'd0);
    if (chg) begin
      in4[0] = 16'd0; in4[1] = 16'd0; in4[2] = 16'd0; in4[3] = 16'd0;
    end
    @(negedge clk);
    if (dbl) se4 = 1'b1;
    @(negedge clk);
    se4 = 1'b0;
    check({tag, ".ovr2"}, 32'(ovr4), 32'(dbl));
    @(negedge clk);
    check({tag, ".ovr3"}, 32'(ovr4), 32'd0);
    check({tag, ".val3"}, 32'(val4), 32'd0);
    @(negedge clk);
    check({tag, ".val4"}, 32'(val4), 32'd0);
    check({tag, ".busy4"}, 32'(busy4), 32'd1);
    @(negedge clk);
    check({tag, ".val5"}, 32'(val4), 32'd1);
    check({tag, ".out"}, 32'(out4), 32'(exp));
    check({tag, ".busy5"}, 32'(busy4), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    se2 = 1'b1; se4 = 1'b1;
    mute2 = '0; mute4 = '0;
    for (int i = 0; i < 2; i++) in2[i] = 16'd0;
    for (int i = 0; i < 4; i++) in4[i] = 16'd0;
    repeat (3) @(negedge clk);
    check("rst.out2", 32'(out2), 32'd0);
    check("rst.val2", 32'(val2), 32'd0);
    check("rst.busy2", 32'(busy2), 32'd0);
    check("rst.ovr2", 32'(ovr2), 32'd0);
    check("rst.out4", 32'(out4), 32'd0);
    check("rst.busy4", 32'(busy4), 32'd0);
    check("rst.ovr4", 32'(ovr4), 32'd0);
`ifdef MIXER_SEQ_OVERRUN_CNT_EN
    check("rst.cnt4", 32'(cnt4), 32'd0);
`endif
    reset_n = 1'b1; se2 = 1'b0; se4 = 1'b0;
    @(negedge clk);
    check("rel.busy4", 32'(busy4), 32'd0);

    // Unequal weights, mute and truncation on the 2-channel mixer.
    mix2(16'd40000, 16'd0,     2'b00, 16'd30000, "m2_a");
    mix2(16'd40000, 16'd0,     2'b01, 16'd0,     "m2_mute0");
    mix2(16'd0,     16'd40000, 2'b00, 16'd9999,  "m2_b");
    mix2(16'd1000,  16'd3000,  2'b00, 16'd1499,  "m2_c");
    mix2(16'd40000, 16'd40000, 2'b10, 16'd30000, "m2_mute1");
    mix2(16'd65535, 16'd65535, 2'b00, 16'd65534, "m2_full");
    @(negedge clk);
    check("m2.val_pulse", 32'(val2), 32'd0);
    check("m2.out_hold", 32'(out2), 32'd65534);

    // Full scale, snapshot isolation, overrun.
    mix4(16'd65535, 16'd65535, 16'd65535, 16'd65535, 4'b0000, 16'd65535, 1'b0, 1'b0, "m4_full");
    @(negedge clk);
    mix4(16'd65535, 16'd65535, 16'd65535, 16'd65535, 4'b0000, 16'd65535, 1'b1, 1'b0, "m4_snap");
    @(negedge clk);
    mix4(16'd100, 16'd200, 16'd300, 16'd400, 4'b0000, 16'd250, 1'b0, 1'b1, "m4_ovr");
`ifdef MIXER_SEQ_OVERRUN_CNT_EN
    check("m4.cnt1", 32'(cnt4), 32'd1);
`endif

    // Back-to-back at the minimum period of N+2 cycles.
    mix4(16'd1,     16'd2,    16'd3,    16'd5,    4'b0000, 16'd2,     1'b0, 1'b0, "b2b_0");
    mix4(16'd65535, 16'd0,    16'd0,    16'd1,    4'b0000, 16'd16384, 1'b0, 1'b0, "b2b_1");
    mix4(16'd1000,  16'd2000, 16'd3000, 16'd4003, 4'b0000, 16'd2500,  1'b0, 1'b0, "b2b_2");
    mix4(16'd100,   16'd200,  16'd300,  16'd400,  4'b0101, 16'd150,   1'b0, 1'b0, "b2b_3");
    mix4(16'd7,     16'd7,    16'd7,    16'd7,    4'b0000, 16'd7,     1'b0, 1'b0, "b2b_4");
    @(negedge clk);
    check("b2b.val_pulse", 32'(val4), 32'd0);
    check("b2b.out_hold", 32'(out4), 32'd7);

    // Continuous strobe: far more than 255 rejections.
    se4 = 1'b1;
    repeat (400) @(negedge clk);
    se4 = 1'b0;
    repeat (8) @(negedge clk);
    check("sat.busy", 32'(busy4), 32'd0);
`ifdef MIXER_SEQ_OVERRUN_CNT_EN
    check("sat.cnt", 32'(cnt4), 32'd255);
`endif

    // Reset in the middle of a mix.
    in4[0] = 16'd9; in4[1] = 16'd9; in4[2] = 16'd9; in4[3] = 16'd9; mute4 = '0;
    se4 = 1'b1;
    @(negedge clk);
    se4 = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid.out", 32'(out4), 32'd0);
    check("mid.val", 32'(val4), 32'd0);
    check("mid.busy", 32'(busy4), 32'd0);
    check("mid.ovr", 32'(ovr4), 32'd0);
`ifdef MIXER_SEQ_OVERRUN_CNT_EN
    check("mid.cnt", 32'(cnt4), 32'd0);
`endif
    se4 = 1'b1;
    @(negedge clk);
    check("mid.busy_rst_se", 32'(busy4), 32'd0);
    check("mid.ovr_rst_se", 32'(ovr4), 32'd0);
    reset_n = 1'b1; se4 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mid.no_val", 32'(val4), 32'd0);
    end
    mix4(16'd400, 16'd400, 16'd400, 16'd401, 4'b0000, 16'd400, 1'b0, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
